// File: rtl/mux_channel_scheduler_if.sv
// mux_channel_scheduler_if: request/mux-return bundle between a requester and the channel scheduler.
interface mux_channel_scheduler_if;
    logic       ENABLE;
    logic [3:0] REQ;
    logic [4:0] MUX_IN;
    logic [1:0] SEL;
    logic [3:0] GNT;
    logic [4:0] DATA_OUT;
    logic       DATA_VALID;
    logic       BUSY;
    modport master (output ENABLE, REQ, MUX_IN, input SEL, GNT, DATA_OUT, DATA_VALID, BUSY);
    modport slave  (input ENABLE, REQ, MUX_IN, output SEL, GNT, DATA_OUT, DATA_VALID, BUSY);
endinterface

// File: rtl/mux_channel_scheduler.sv
// mux_channel_scheduler: round-robin grant of a 4-way mux, settle then capture, then dwell before release.
module mux_channel_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int DWELL_CYCLES  = 4
) (
    input logic CLK,
    input logic RESET,
    mux_channel_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_cnt;
    logic [1:0] r_last, r_sel, w_win;
    logic [3:0] r_gnt;
    logic [4:0] r_data;
    logic       r_dv;
    logic       w_found, w_req_sel, w_grant, w_abort, w_capture, w_release;
    // search starts one past the last served channel so every requester gets a turn
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && bus.REQ[r_last + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_last + 2'(k);
            end
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_grant ? SETTLE : IDLE;
            SETTLE:  w_next = w_abort ? IDLE : (w_capture ? HOLD : SETTLE);
            HOLD:    w_next = w_release ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_req_sel = bus.REQ[r_sel];
        w_grant   = r_state == IDLE && bus.ENABLE && w_found;
        w_abort   = r_state == SETTLE && !w_req_sel;
        w_capture = r_state == SETTLE && w_req_sel && r_cnt == 8'(SETTLE_CYCLES - 1);
        w_release = r_state == HOLD && (!w_req_sel || r_cnt == 8'(DWELL_CYCLES - 1));
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_last <= 2'd3;
            r_sel  <= '0;
            r_gnt  <= '0;
            r_data <= '0;
            r_dv   <= 1'b0;
        end else begin
            r_dv  <= w_capture;
            r_cnt <= (w_grant || w_capture) ? 8'd0 : (r_state != IDLE ? r_cnt + 8'd1 : r_cnt);
            if (w_grant) begin
                r_sel <= w_win;
                r_gnt <= 4'b0001 << w_win;
            end
            if (w_abort || w_release) r_gnt <= '0;
            if (w_release) r_last <= r_sel;
            if (w_capture) r_data <= bus.MUX_IN;
        end
    end
    assign bus.SEL        = r_sel;
    assign bus.GNT        = r_gnt;
    assign bus.DATA_OUT   = r_data;
    assign bus.DATA_VALID = r_dv;
    assign bus.BUSY       = r_state != IDLE;
endmodule

// File: tb/tb_mux_channel_scheduler.sv
// tb_mux_channel_scheduler: directed checks of grant order, settle/capture timing, release, abort, enable and reset.
module tb_mux_channel_scheduler;
    logic CLK;
    logic RESET;
    int   total = 0;
    int   bad   = 0;
    mux_channel_scheduler_if ifc ();
    mux_channel_scheduler dut (.CLK(CLK), .RESET(RESET), .bus(ifc));
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    task automatic nxt(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, 8'(ifc.SEL), 8'h0);
        chk({tag, "_gnt"}, 8'(ifc.GNT), 8'h0);
        chk({tag, "_data"}, 8'(ifc.DATA_OUT), 8'h0);
        chk({tag, "_dv"}, 8'(ifc.DATA_VALID), 8'h0);
        chk({tag, "_busy"}, 8'(ifc.BUSY), 8'h0);
    endtask
    initial begin
        RESET = 1'b1;
        ifc.ENABLE = 1'b0;
        ifc.REQ = 4'b0000;
        ifc.MUX_IN = 5'h00;
        #3;
        chk_reset("init");
        nxt(1);
        RESET = 1'b0;
        // single request on channel 1
        ifc.ENABLE = 1'b1;
        ifc.REQ = 4'b0010;
        ifc.MUX_IN = 5'h15;
        nxt(1);
        chk("single_gnt_c1", 8'(ifc.GNT), 8'h02);
        chk("single_sel_c1", 8'(ifc.SEL), 8'h01);
        chk("single_busy_c1", 8'(ifc.BUSY), 8'h01);
        nxt(1);
        chk("single_dv_c2", 8'(ifc.DATA_VALID), 8'h00);
        nxt(1);
        chk("single_dv_c3", 8'(ifc.DATA_VALID), 8'h01);
        chk("single_data_c3", 8'(ifc.DATA_OUT), 8'h15);
        nxt(1);
        chk("single_dv_c4", 8'(ifc.DATA_VALID), 8'h00);
        nxt(2);
        chk("single_gnt_c6", 8'(ifc.GNT), 8'h02);
        nxt(1);
        chk("single_gnt_c7", 8'(ifc.GNT), 8'h00);
        chk("single_busy_c7", 8'(ifc.BUSY), 8'h00);
        // early release on channel 2, then 0101 must go to channel 0
        ifc.REQ = 4'b0100;
        ifc.MUX_IN = 5'h0A;
        nxt(1);
        chk("early_gnt_c1", 8'(ifc.GNT), 8'h04);
        chk("early_sel_c1", 8'(ifc.SEL), 8'h02);
        nxt(2);
        chk("early_dv_c3", 8'(ifc.DATA_VALID), 8'h01);
        chk("early_data_c3", 8'(ifc.DATA_OUT), 8'h0A);
        nxt(1);
        chk("early_gnt_c4", 8'(ifc.GNT), 8'h04);
        ifc.REQ = 4'b0000;
        nxt(1);
        chk("early_gnt_c5", 8'(ifc.GNT), 8'h00);
        chk("early_busy_c5", 8'(ifc.BUSY), 8'h00);
        ifc.REQ = 4'b0101;
        nxt(1);
        chk("rr_gnt_after_2", 8'(ifc.GNT), 8'h01);
        chk("rr_sel_after_2", 8'(ifc.SEL), 8'h00);
        ifc.REQ = 4'b0000;
        nxt(1);
        chk("abort0_gnt", 8'(ifc.GNT), 8'h00);
        chk("abort0_dv", 8'(ifc.DATA_VALID), 8'h00);
        // abort of channel 3 during settle keeps old data
        ifc.REQ = 4'b1000;
        ifc.MUX_IN = 5'h1F;
        nxt(1);
        chk("abort_gnt_c1", 8'(ifc.GNT), 8'h08);
        chk("abort_sel_c1", 8'(ifc.SEL), 8'h03);
        ifc.REQ = 4'b0000;
        nxt(1);
        chk("abort_gnt_c2", 8'(ifc.GNT), 8'h00);
        chk("abort_busy_c2", 8'(ifc.BUSY), 8'h00);
        chk("abort_dv_c2", 8'(ifc.DATA_VALID), 8'h00);
        nxt(1);
        chk("abort_dv_c3", 8'(ifc.DATA_VALID), 8'h00);
        chk("abort_data_c3", 8'(ifc.DATA_OUT), 8'h0A);
        // enable low blocks new grants but not one in progress
        ifc.ENABLE = 1'b0;
        ifc.REQ = 4'b0001;
        nxt(3);
        chk("en_blocked_gnt", 8'(ifc.GNT), 8'h00);
        chk("en_blocked_busy", 8'(ifc.BUSY), 8'h00);
        ifc.ENABLE = 1'b1;
        nxt(1);
        chk("en_gnt_c1", 8'(ifc.GNT), 8'h01);
        nxt(2);
        chk("en_dv_c3", 8'(ifc.DATA_VALID), 8'h01);
        chk("en_data_c3", 8'(ifc.DATA_OUT), 8'h1F);
        nxt(1);
        ifc.ENABLE = 1'b0;
        nxt(2);
        chk("en_gnt_c6", 8'(ifc.GNT), 8'h01);
        nxt(1);
        chk("en_gnt_c7", 8'(ifc.GNT), 8'h00);
        nxt(1);
        chk("en_gnt_c8", 8'(ifc.GNT), 8'h00);
        chk("en_busy_c8", 8'(ifc.BUSY), 8'h00);
        // reset, then fairness with all channels requesting
        RESET = 1'b1;
        #1;
        chk_reset("rst2");
        nxt(1);
        RESET = 1'b0;
        ifc.REQ = 4'b1111;
        ifc.ENABLE = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            nxt(1);
            if (c % 7 == 1) chk($sformatf("fair_gnt_c%0d", c), 8'(ifc.GNT), 8'(1 << ((c / 7) % 4)));
            if (c % 7 == 0) chk($sformatf("fair_gap_c%0d", c), 8'(ifc.GNT), 8'h00);
            if (c % 7 == 3) chk($sformatf("fair_dv_c%0d", c), 8'(ifc.DATA_VALID), 8'h01);
        end
        // async reset mid-cycle during hold
        nxt(3);
        chk("hold_busy", 8'(ifc.BUSY), 8'h01);
        chk("hold_gnt", 8'(ifc.GNT), 8'h01);
        chk("hold_data", 8'(ifc.DATA_OUT), 8'h1F);
        #2;
        RESET = 1'b1;
        #1;
        chk_reset("async");
        nxt(1);
        chk("async_hold_dv", 8'(ifc.DATA_VALID), 8'h00);
        chk("async_hold_gnt", 8'(ifc.GNT), 8'h00);
        RESET = 1'b0;
        nxt(1);
        chk("post_rst_gnt", 8'(ifc.GNT), 8'h01);
        chk("post_rst_sel", 8'(ifc.SEL), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_channel_scheduler.md
MUX_CHANNEL_SCHEDULER -- requirements
Module: mux_channel_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles the selected 4-way mux path settles before capture (legal 1..255).
REQ-002 Parameter DWELL_CYCLES, default 4: maximum cycles a grant is held after capture (legal 1..255).
REQ-003 Port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-high reset.
REQ-005 Port ENABLE  input  1  high permits new grants; low blocks new grants only.
REQ-006 Port REQ  input  4  per-channel request; bit i requests mux input INi.
REQ-007 Port MUX_IN  input  5  5-bit output of the 4-way mux, returned to this block.
REQ-008 Port SEL  output  2  drives the mux CONTROL select; registered.
REQ-009 Port GNT  output  4  one-hot grant to the requester being served; registered.
REQ-010 Port DATA_OUT  output  5  sample of MUX_IN captured for the granted channel; registered.
REQ-011 Port DATA_VALID  output  1  one-cycle pulse when DATA_OUT is updated.
REQ-012 Port BUSY  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE and HOLD, plus an internal 8-bit cycle counter and a 2-bit LAST pointer.
REQ-014 IDLE: if ENABLE=1 and REQ!=0, the next edge SHALL set SEL to the winner, GNT to its one-hot, clear the counter and enter SETTLE; otherwise it SHALL stay in IDLE with GNT=0 and SEL unchanged.
REQ-015 The winner SHALL be chosen round-robin: the first asserted REQ bit searching LAST+1, LAST+2, LAST+3, LAST, modulo 4, with wrap-around from 3 to 0.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles.
REQ-017 On the edge ending SETTLE, the block SHALL load DATA_OUT<=MUX_IN, assert DATA_VALID for one cycle, clear the counter and enter HOLD.
REQ-018 If REQ[SEL] is low in any SETTLE cycle, the next edge SHALL abort to IDLE: GNT=0, no capture, no DATA_VALID, and LAST unchanged.
REQ-019 HOLD SHALL last until DWELL_CYCLES cycles elapse or REQ[SEL] is sampled low, whichever comes first.
REQ-020 The edge leaving HOLD SHALL set GNT=0, set LAST<=SEL and enter IDLE.
REQ-021 Every grant SHALL be separated by at least one IDLE cycle with GNT=0 (turnaround).
REQ-022 SEL SHALL change only on the IDLE-to-SETTLE edge and SHALL remain stable through SETTLE and HOLD.
REQ-023 ENABLE low during SETTLE or HOLD SHALL NOT affect the operation in progress.
REQ-024 Changes of REQ bits other than REQ[SEL] during SETTLE or HOLD SHALL be ignored until the next IDLE cycle.
REQ-025 DATA_OUT SHALL hold its last captured value between captures.
REQ-026 Timing: with REQ sampled in IDLE at cycle 0, GNT and SEL are valid at cycle 1, DATA_VALID is high at cycle 1+SETTLE_CYCLES, and GNT falls at cycle 1+SETTLE_CYCLES+DWELL_CYCLES.
REQ-027 Under a continuous single request, the grant period SHALL be SETTLE_CYCLES+DWELL_CYCLES+1 cycles.

Reset
REQ-028 While RESET=1, asynchronously and regardless of CLK, the block SHALL hold: state=IDLE, counter=0, LAST=3, SEL=00, GNT=0000, DATA_OUT=00000, DATA_VALID=0, BUSY=0.
REQ-029 RESET asserted mid-SETTLE or mid-HOLD SHALL abandon the operation with no DATA_VALID.
REQ-030 After RESET is released, the first grant SHALL give channel 0 highest priority.

Verification
REQ-031 Reset: assert RESET asynchronously mid-cycle during HOLD -> all outputs reach their REQ-028 values immediately, with no wait for an edge.
REQ-032 Single request: REQ=0010 at cycle 0, MUX_IN=5'h15 -> GNT=0010 and SEL=01 at cycle 1, DATA_VALID=1 and DATA_OUT=5'h15 at cycle 3, GNT=0000 at cycle 7.
REQ-033 Fairness: REQ=1111 held after reset -> grants go 0,1,2,3,0 on a 7-cycle period with a GNT=0000 gap of one cycle between grants.
REQ-034 Early release: REQ=0100 granted, REQ dropped at cycle 4 -> GNT=0000 at cycle 5 and LAST=2; a following REQ=0101 is granted to channel 0.
REQ-035 Abort: REQ=1000 dropped at cycle 1 (SETTLE) -> GNT=0000 at cycle 2, no DATA_VALID, and DATA_OUT unchanged.
REQ-036 ENABLE: ENABLE=0 with REQ=0001 -> GNT stays 0000; ENABLE dropped during HOLD -> the current grant still completes the full dwell.
